vram_arbiter: RTL
=================

# vram_arbiter

Shares the single-port video RAM between two requesters: the VGA scan-out fetch path (read-only, latency-critical) and the CPU load/store path (read/write). At most one access is issued per cycle, to a single RAM port. Read data is routed back to the owner with a fixed latency. Sits between the CPU core, the VGA line fetcher and the VRAM macro, all in the `clock` domain.

## Interface
Parameters:
- `ADDR_W`, default 16: VRAM word-address width.
- `DATA_W`, default 16: VRAM word width.
- `MAX_WAIT`, default 8: the number of consecutive denied CPU request cycles after which the CPU is force-granted. Only used with the starvation guard; legal range 1..255.

Ports:
- `clock`  in  1: sole clock; all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `vga_req`  in  1: VGA read request; held until granted.
- `vga_addr`  in  ADDR_W: VGA read address.
- `vga_gnt`  out  1: VGA request accepted this cycle.
- `vga_rvalid`  out  1: `vga_rdata` is valid.
- `vga_rdata`  out  DATA_W: VGA read data.
- `cpu_req`  in  1: CPU request; held, with stable fields, until granted.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_gnt`  out  1: CPU request accepted this cycle.
- `cpu_rvalid`  out  1: `cpu_rdata` is valid.
- `cpu_rdata`  out  DATA_W: CPU read data.
- `mem_en`  out  1: RAM access strobe.
- `mem_we`  out  1: RAM write enable.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_wdata`  out  DATA_W: RAM write data.
- `mem_rdata`  in  DATA_W: RAM read data. It is valid in the cycle after a read with `mem_en`=1.

## Operation
- Grant logic is combinational from the requests and registered arbiter state:
  - At most one of `vga_gnt` or `cpu_gnt` is high per cycle.
  - Both grants are forced to 0 while `reset` is high.
- A request and its fields are consumed in a cycle where req & gnt.
- Priority:
  - VGA wins when both requesters are active.
  - The CPU is granted when `cpu_req`=1 and either `vga_req`=0 or the starvation guard fires.
- Command stage (registered): in the cycle after a grant, `mem_en`=1 and `mem_addr`, `mem_we` and `mem_wdata` carry the granted request. In a cycle after no grant, `mem_en`=0, `mem_we`=0, and address and data hold their last values.
- Read return pipeline, two stages:
  - Each stage holds a tag {valid, owner}. Owner is `OWN_VGA` or `OWN_CPU`; writes produce no tag.
  - At stage 2, `mem_rdata` is registered into the owner's `*_rdata` and that owner's `*_rvalid` pulses for one cycle.
  - The non-owner's rdata holds its previous value.
- Writes produce no response. RAM order equals grant order, so a CPU read granted after a CPU write to the same address returns the new data.
- Reset values: all `mem_*` outputs 0, both `*_rvalid` 0, both `*_rdata` 0, pipeline tags invalid, wait counter 0.
- Reset mid-operation: in-flight reads are discarded and no `rvalid` is produced for them. Requesters must re-issue after reset.

## Timing
- Grant in cycle t → `mem_en` in t+1 → `mem_rdata` in t+2 → `*_rvalid` and `*_rdata` in t+3. Read latency is fixed at 3 cycles from grant.
- Throughput is one access per cycle. Back-to-back grants yield back-to-back `rvalid`s in grant order.
- No combinational path from `mem_rdata` to any output.

## Configuration
`VRAM_ARB_STARVE_GUARD_EN`:
- Defined:
  - An 8-bit wait counter increments in each cycle with `cpu_req`=1 and `cpu_gnt`=0.
  - It clears on `cpu_gnt` or when `cpu_req`=0.
  - When the counter equals `MAX_WAIT`, the CPU is granted even if `vga_req`=1; VGA is denied that cycle.
- Undefined: strict VGA priority. The counter and `MAX_WAIT` logic are not synthesized, and the CPU can starve indefinitely.

## Structure
- Package `vram_pkg`:
  - `owner_e` enum: `OWN_VGA`, `OWN_CPU`.
  - `rd_tag_t` struct: {valid, owner}.
  - Default `VRAM_ADDR_W` and `VRAM_DATA_W` localparams.
- Sub-module `vram_rd_pipe`: the two-stage tag shift register plus the rdata/rvalid demux. It has the same clock and reset.
- The grant logic, command register and wait counter stay in `vram_arbiter`.

## Test plan
- Reset release: all outputs 0 for the first cycle. Then `cpu_req`=1 and `cpu_we`=0 at address 0x0010 alone gives `cpu_gnt`=1 at t, `mem_en`=1 with `mem_addr`=0x0010 at t+1, and `cpu_rvalid`=1 with `cpu_rdata` equal to the RAM content at t+3.
- CPU write then read:
  - Write 0xBEEF to 0x0042; then read 0x0042.
  - Required: `mem_we`=1 only in the write's command cycle, and `cpu_rdata`=0xBEEF. No `rvalid` for the write.
- Simultaneous requests, guard off: `vga_req` and `cpu_req` held for 20 cycles gives `vga_gnt`=1 every cycle and `cpu_gnt`=0 throughout.
- Simultaneous requests, guard on, `MAX_WAIT`=8:
  - First `cpu_gnt` at cycle 8 of contention, then every 9th cycle.
  - `vga_gnt`=0 exactly in those cycles.
  - `vga_rvalid` and `cpu_rvalid` return in grant order 3 cycles later.
- Interleaved reads (VGA at 0x0100 in t, CPU at 0x0200 in t+1): `vga_rvalid` at t+3 with the 0x0100 data and `cpu_rvalid` at t+4 with the 0x0200 data. Non-owner rdata is unchanged.
- Reset asserted at t+1 after a read grant at t, released at t+2: no `rvalid` in t+2..t+5, and all outputs 0 while reset is high.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter and its read-return pipeline.
package vram_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 16;

    // Which requester a read response belongs to
    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    // Read-return tag carried alongside each RAM read
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_VGA};

    // Build a valid tag for a read issued on behalf of the given owner
    function automatic rd_tag_t make_rd_tag(input owner_e owner);
        rd_tag_t tag;
        tag.valid = 1'b1;
        tag.owner = owner;
        return tag;
    endfunction

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-return pipeline: delays the read tag by two cycles so that it lines up
// with mem_rdata, then registers the data into the owning requester's port.
module vram_rd_pipe
    import vram_pkg::*;
#(
    parameter int DATA_W = VRAM_DATA_W
)
(
    input  logic              clock,
    input  logic              reset,
    input  rd_tag_t           tag_p0,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata
);

    rd_tag_t tag_p1;
    rd_tag_t tag_p2;

    // grant -> command cycle (p1) -> RAM data cycle (p2); reset drops in-flight reads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_p1 <= TAG_NONE;
            tag_p2 <= TAG_NONE;
        end else begin
            tag_p1 <= tag_p0;
            tag_p2 <= tag_p1;
        end
    end

    // p2 -> output: steer RAM data to its owner; the other side keeps its last word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            vga_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            vga_rvalid <= tag_p2.valid && (tag_p2.owner == OWN_VGA);
            cpu_rvalid <= tag_p2.valid && (tag_p2.owner == OWN_CPU);
            if (tag_p2.valid && (tag_p2.owner == OWN_VGA)) begin
                vga_rdata <= mem_rdata;
            end
            if (tag_p2.valid && (tag_p2.owner == OWN_CPU)) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the VGA scan-out fetcher (read-only, high
// priority) and the CPU load/store path. One access per cycle, reads return
// to their owner three cycles after grant.
// Optional macro VRAM_ARB_STARVE_GUARD_EN: force-grants the CPU after MAX_WAIT
// consecutive denied request cycles; without it VGA has strict priority.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int MAX_WAIT = 8
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic    starve_fire;
    rd_tag_t tag_p0;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_check
        $error("vram_arbiter: MAX_WAIT must lie in 1..255");
    end

`ifdef VRAM_ARB_STARVE_GUARD_EN
    logic [7:0] wait_cnt;

    // Count consecutive cycles in which the CPU asks but is refused
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (cpu_gnt || !cpu_req) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign starve_fire = (wait_cnt == 8'(MAX_WAIT));
`else
    assign starve_fire = 1'b0;
`endif

    // Grant decision: VGA first unless the starvation guard has fired
    always_comb begin
        vga_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!reset) begin
            cpu_gnt = cpu_req && (!vga_req || starve_fire);
            vga_gnt = vga_req && !cpu_gnt;
        end
    end

    // Grant cycle (p0): tag every granted read with its owner; writes carry none
    always_comb begin
        tag_p0 = TAG_NONE;
        if (vga_gnt) begin
            tag_p0 = make_rd_tag(OWN_VGA);
        end else if (cpu_gnt && !cpu_we) begin
            tag_p0 = make_rd_tag(OWN_CPU);
        end
    end

    // p0 -> command cycle: present the granted access to the RAM port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (cpu_gnt) begin
            mem_en    <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end else if (vga_gnt) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= vga_addr;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    vram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clock      (clock),
        .reset      (reset),
        .tag_p0     (tag_p0),
        .mem_rdata  (mem_rdata),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata)
    );

endmodule
